mem_ctrl: RTL and testbench

- Single arbiter between the CPU core and the byte-wide unified RAM port.
- Serves three requesters: instruction fetches (fetcher), loads (LSB), and committed stores (ROB).
- Latches each one-cycle request pulse, serialises the access into little-endian byte transfers, assembles and sign/zero-extends load data, and returns a one-cycle done pulse to the requester.
- Sits directly downstream of the LSB memory interface and of the fetcher/ROB memory ports.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encoding,
// data width and the internal 3-bit access size codes.
package mem_ctrl_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    // Narrow the 6-bit request size to the 3-bit byte count used internally.
    // Undefined sizes collapse to a word access.
    function automatic logic [2:0] size_code(input logic [5:0] size);
        case (size)
            6'd1:    size_code = SIZE_BYTE;
            6'd2:    size_code = SIZE_HALF;
            default: size_code = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter between the CPU core and the byte-wide unified RAM port.
// Latches one-cycle request pulses from the fetcher, the LSB (loads) and the
// ROB (committed stores), serves them store > load > fetch as little-endian
// byte sequences, and returns a one-cycle done pulse to each requester.
//
// Ports:
//   clk, rst (async, active-low), rdy (global enable, low freezes state)
//   in_rob_misbranch            flush of speculative fetch/load traffic
//   in_fetcher_* / out_fetcher_*  instruction fetch request / done + word
//   in_lsb_*     / out_lsb_*      load request / done + extended data
//   in_rob_*     / out_rob_ce     store request / done
//   mem_din, mem_dout, mem_a, mem_wr  byte-wide RAM port
//   io_buffer_full               back-pressure for stores into the I/O region
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_rob_misbranch,
    input  logic              in_fetcher_ce,
    input  logic [ADDR_W-1:0] in_fetcher_addr,
    output logic              out_fetcher_ce,
    output logic [31:0]       out_fetcher_data,
    input  logic              in_lsb_ce,
    input  logic [5:0]        in_lsb_size,
    input  logic              in_lsb_signed,
    input  logic [ADDR_W-1:0] in_lsb_addr,
    output logic              out_lsb_ce,
    output logic [31:0]       out_lsb_data,
    input  logic              in_rob_ce,
    input  logic [5:0]        in_rob_size,
    input  logic [ADDR_W-1:0] in_rob_addr,
    input  logic [31:0]       in_rob_data,
    output logic              out_rob_ce,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    import mem_ctrl_pkg::*;

    // Active transfer
    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [ADDR_W-1:0]       op_addr_q, op_addr_d;
    logic [2:0]              op_size_q, op_size_d;
    logic                    op_signed_q, op_signed_d;
    logic [DATA_WIDTH-1:0]   op_data_q, op_data_d;

    // Pending request slots
    logic                    fetch_pend_q, fetch_pend_d;
    logic [ADDR_W-1:0]       fetch_addr_q, fetch_addr_d;
    logic                    load_pend_q, load_pend_d;
    logic [ADDR_W-1:0]       load_addr_q, load_addr_d;
    logic [2:0]              load_size_q, load_size_d;
    logic                    load_signed_q, load_signed_d;
    logic                    store_pend_q, store_pend_d;
    logic [ADDR_W-1:0]       store_addr_q, store_addr_d;
    logic [2:0]              store_size_q, store_size_d;
    logic [DATA_WIDTH-1:0]   store_data_q, store_data_d;

    // Registered requester outputs
    logic                    fetch_ce_q, fetch_ce_d;
    logic [DATA_WIDTH-1:0]   fetch_data_q, fetch_data_d;
    logic                    lsb_ce_q, lsb_ce_d;
    logic [DATA_WIDTH-1:0]   lsb_data_q, lsb_data_d;
    logic                    rob_ce_q, rob_ce_d;

    logic                    io_block;
    logic [1:0]              byte_idx;

    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [2:0]            size,
        input logic                  sgn
    );
        case (size)
            SIZE_BYTE: extend_load = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
            SIZE_HALF: extend_load = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default:   extend_load = raw;
        endcase
    endfunction

    // A store into the I/O region stalls on its current byte while the I/O
    // buffer is full.
    assign io_block = (op_addr_q[17:16] == IO_SEL) && io_buffer_full;

    // Read data lags its address by one cycle, so count k captures byte k-1.
    assign byte_idx = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_addr_d     = op_addr_q;
        op_size_d     = op_size_q;
        op_signed_d   = op_signed_q;
        op_data_d     = op_data_q;
        fetch_pend_d  = fetch_pend_q;
        fetch_addr_d  = fetch_addr_q;
        load_pend_d   = load_pend_q;
        load_addr_d   = load_addr_q;
        load_size_d   = load_size_q;
        load_signed_d = load_signed_q;
        store_pend_d  = store_pend_q;
        store_addr_d  = store_addr_q;
        store_size_d  = store_size_q;
        store_data_d  = store_data_q;
        fetch_ce_d    = 1'b0;
        fetch_data_d  = fetch_data_q;
        lsb_ce_d      = 1'b0;
        lsb_data_d    = lsb_data_q;
        rob_ce_d      = 1'b0;

        if (in_fetcher_ce) begin
            fetch_pend_d = 1'b1;
            fetch_addr_d = in_fetcher_addr;
        end
        if (in_lsb_ce) begin
            load_pend_d   = 1'b1;
            load_addr_d   = in_lsb_addr;
            load_size_d   = size_code(in_lsb_size);
            load_signed_d = in_lsb_signed;
        end
        if (in_rob_ce) begin
            store_pend_d = 1'b1;
            store_addr_d = in_rob_addr;
            store_size_d = size_code(in_rob_size);
            store_data_d = in_rob_data;
        end
        // Speculative traffic is dropped, including pulses of this very cycle.
        // Stores are already committed and are never flushed.
        if (in_rob_misbranch) begin
            fetch_pend_d = 1'b0;
            load_pend_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Slot *_d values merge pending requests with same-cycle pulses.
                if (store_pend_d) begin
                    store_pend_d = 1'b0;
                    state_d      = ST_STORE;
                    cnt_d        = 3'd0;
                    op_addr_d    = store_addr_d;
                    op_size_d    = store_size_d;
                    op_signed_d  = 1'b0;
                    op_data_d    = store_data_d;
                end else if (load_pend_d) begin
                    load_pend_d = 1'b0;
                    state_d     = ST_LOAD;
                    cnt_d       = 3'd0;
                    op_addr_d   = load_addr_d;
                    op_size_d   = load_size_d;
                    op_signed_d = load_signed_d;
                    op_data_d   = '0;
                end else if (fetch_pend_d) begin
                    fetch_pend_d = 1'b0;
                    state_d      = ST_FETCH;
                    cnt_d        = 3'd0;
                    op_addr_d    = fetch_addr_d;
                    op_size_d    = SIZE_WORD;
                    op_signed_d  = 1'b0;
                    op_data_d    = '0;
                end
            end
            ST_FETCH, ST_LOAD: begin
                if (in_rob_misbranch) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != 3'd0) begin
                        op_data_d[{byte_idx, 3'b000} +: 8] = mem_din;
                    end
                    if (cnt_q == op_size_q) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_FETCH) begin
                            fetch_ce_d   = 1'b1;
                            fetch_data_d = op_data_d;
                        end else begin
                            lsb_ce_d   = 1'b1;
                            lsb_data_d = extend_load(op_data_d, op_size_q, op_signed_q);
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_STORE: begin
                if (!io_block) begin
                    if (cnt_q == op_size_q - 3'd1) begin
                        state_d  = ST_IDLE;
                        rob_ce_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_addr_q     <= '0;
            op_size_q     <= '0;
            op_signed_q   <= 1'b0;
            op_data_q     <= '0;
            fetch_pend_q  <= 1'b0;
            fetch_addr_q  <= '0;
            load_pend_q   <= 1'b0;
            load_addr_q   <= '0;
            load_size_q   <= '0;
            load_signed_q <= 1'b0;
            store_pend_q  <= 1'b0;
            store_addr_q  <= '0;
            store_size_q  <= '0;
            store_data_q  <= '0;
            fetch_ce_q    <= 1'b0;
            fetch_data_q  <= '0;
            lsb_ce_q      <= 1'b0;
            lsb_data_q    <= '0;
            rob_ce_q      <= 1'b0;
        end else if (rdy) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_addr_q     <= op_addr_d;
            op_size_q     <= op_size_d;
            op_signed_q   <= op_signed_d;
            op_data_q     <= op_data_d;
            fetch_pend_q  <= fetch_pend_d;
            fetch_addr_q  <= fetch_addr_d;
            load_pend_q   <= load_pend_d;
            load_addr_q   <= load_addr_d;
            load_size_q   <= load_size_d;
            load_signed_q <= load_signed_d;
            store_pend_q  <= store_pend_d;
            store_addr_q  <= store_addr_d;
            store_size_q  <= store_size_d;
            store_data_q  <= store_data_d;
            fetch_ce_q    <= fetch_ce_d;
            fetch_data_q  <= fetch_data_d;
            lsb_ce_q      <= lsb_ce_d;
            lsb_data_q    <= lsb_data_d;
            rob_ce_q      <= rob_ce_d;
        end
    end

    assign mem_a    = (state_q == ST_IDLE) ? '0 : op_addr_q + ADDR_W'(cnt_q);
    assign mem_wr   = rdy && (state_q == ST_STORE) && !io_block;
    assign mem_dout = (state_q == ST_STORE) ? op_data_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;

    assign out_fetcher_ce   = fetch_ce_q;
    assign out_fetcher_data = fetch_data_q;
    assign out_lsb_ce       = lsb_ce_q;
    assign out_lsb_data     = lsb_data_q;
    assign out_rob_ce       = rob_ce_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM model, scoreboard of
// expected done pulses, and directed cycle-level checks of the RAM port.
module tb_mem_ctrl;
    localparam int ADDR_W = 32;
    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_LSB   = 2'd1;
    localparam logic [1:0] K_ROB   = 2'd2;

    logic              clk = 1'b0;
    logic              rst, rdy, in_rob_misbranch;
    logic              in_fetcher_ce;
    logic [ADDR_W-1:0] in_fetcher_addr;
    logic              out_fetcher_ce;
    logic [31:0]       out_fetcher_data;
    logic              in_lsb_ce;
    logic [5:0]        in_lsb_size;
    logic              in_lsb_signed;
    logic [ADDR_W-1:0] in_lsb_addr;
    logic              out_lsb_ce;
    logic [31:0]       out_lsb_data;
    logic              in_rob_ce;
    logic [5:0]        in_rob_size;
    logic [ADDR_W-1:0] in_rob_addr;
    logic [31:0]       in_rob_data;
    logic              out_rob_ce;
    logic [7:0]        mem_din, mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    mem_ctrl #(.ADDR_W(ADDR_W), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_rob_misbranch(in_rob_misbranch),
        .in_fetcher_ce(in_fetcher_ce), .in_fetcher_addr(in_fetcher_addr),
        .out_fetcher_ce(out_fetcher_ce), .out_fetcher_data(out_fetcher_data),
        .in_lsb_ce(in_lsb_ce), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
        .in_lsb_addr(in_lsb_addr), .out_lsb_ce(out_lsb_ce), .out_lsb_data(out_lsb_data),
        .in_rob_ce(in_rob_ce), .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr),
        .in_rob_data(in_rob_data), .out_rob_ce(out_rob_ce),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // RAM model: read byte valid one enabled cycle after its address.
    logic [7:0]  ram [0:4095];
    logic        pre_we;
    logic [11:0] pre_a;
    logic [7:0]  pre_d;
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_a] <= pre_d;
        end else if (rdy) begin
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
            mem_din <= ram[mem_a[11:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic got_done(input logic [1:0] kind, input logic [31:0] data);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_done: observed kind %0d expected no done", kind);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("done_kind", 32'(kind), 32'(e.kind));
            if (kind != K_ROB) check("done_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst && rdy) begin
            if (out_rob_ce)     got_done(K_ROB, 32'h0);
            if (out_lsb_ce)     got_done(K_LSB, out_lsb_data);
            if (out_fetcher_ce) got_done(K_FETCH, out_fetcher_data);
        end
    end

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic drive_fetch(input logic [31:0] a, input bit track, input logic [31:0] exp);
        in_fetcher_ce = 1'b1; in_fetcher_addr = a;
        if (track) sb.push_back('{kind: K_FETCH, data: exp});
    endtask

    task automatic drive_load(input logic [31:0] a, input logic [5:0] sz, input logic sg,
                              input bit track, input logic [31:0] exp);
        in_lsb_ce = 1'b1; in_lsb_addr = a; in_lsb_size = sz; in_lsb_signed = sg;
        if (track) sb.push_back('{kind: K_LSB, data: exp});
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [5:0] sz, input logic [31:0] d,
                               input bit track);
        in_rob_ce = 1'b1; in_rob_addr = a; in_rob_size = sz; in_rob_data = d;
        if (track) sb.push_back('{kind: K_ROB, data: 32'h0});
    endtask

    task automatic release_ce();
        tick();
        in_fetcher_ce = 1'b0; in_lsb_ce = 1'b0; in_rob_ce = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        tick();
    endtask

    function automatic logic [31:0] ram_word(input logic [11:0] a);
        return {ram[a + 12'd3], ram[a + 12'd2], ram[a + 12'd1], ram[a]};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sw_data;
        rst = 1'b0; rdy = 1'b1; in_rob_misbranch = 1'b0; io_buffer_full = 1'b0;
        in_fetcher_ce = 1'b0; in_fetcher_addr = '0;
        in_lsb_ce = 1'b0; in_lsb_size = '0; in_lsb_signed = 1'b0; in_lsb_addr = '0;
        in_rob_ce = 1'b0; in_rob_size = '0; in_rob_addr = '0; in_rob_data = '0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;

        poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
        poke(12'h110, 8'h80);
        poke(12'h120, 8'h34); poke(12'h121, 8'h80);
        poke(12'h140, 8'h13); poke(12'h141, 8'h05); poke(12'h142, 8'h00); poke(12'h143, 8'h00);
        poke(12'h150, 8'h0D); poke(12'h151, 8'hF0); poke(12'h152, 8'hFE); poke(12'h153, 8'hCA);
        poke(12'h170, 8'hAA); poke(12'h171, 8'hBB); poke(12'h172, 8'hCC); poke(12'h173, 8'hDD);
        poke(12'h200, 8'h93); poke(12'h201, 8'h00); poke(12'h202, 8'h10); poke(12'h203, 8'h00);

        // Reset state
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_fetch_ce", 32'(out_fetcher_ce), 32'd0);
        check("rst_lsb_ce", 32'(out_lsb_ce), 32'd0);
        check("rst_rob_ce", 32'(out_rob_ce), 32'd0);
        check("rst_lsb_data", out_lsb_data, 32'd0);
        check("rst_fetch_data", out_fetcher_data, 32'd0);
        rst = 1'b1;
        tick(); tick();

        // LW at 0x100: addresses in C+1..C+4, done in C+6
        drive_load(32'h100, 6'd4, 1'b0, 1'b1, 32'h12345678);
        release_ce();
        for (int k = 0; k < 4; k++) begin
            check("lw_addr", mem_a, 32'h100 + 32'(k));
            check("lw_wr", 32'(mem_wr), 32'd0);
            tick();
        end
        check("lw_ce_early", 32'(out_lsb_ce), 32'd0);
        tick();
        check("lw_ce", 32'(out_lsb_ce), 32'd1);
        check("lw_data", out_lsb_data, 32'h12345678);
        tick();

        // LB signed: done in C+3
        drive_load(32'h110, 6'd1, 1'b1, 1'b1, 32'hFFFFFF80);
        release_ce();
        tick();
        check("lb_ce_early", 32'(out_lsb_ce), 32'd0);
        tick();
        check("lb_ce", 32'(out_lsb_ce), 32'd1);
        tick();
        drive_load(32'h110, 6'd1, 1'b0, 1'b1, 32'h00000080);
        release_ce();
        drain(20);
        drive_load(32'h120, 6'd2, 1'b1, 1'b1, 32'hFFFF8034);
        release_ce();
        drain(20);
        drive_load(32'h120, 6'd2, 1'b0, 1'b1, 32'h00008034);
        release_ce();
        drain(20);
        check("lhu_hold", out_lsb_data, 32'h00008034);

        // Simultaneous store, load and fetch: store > load > fetch
        drive_store(32'h160, 6'd4, 32'hDEADBEEF, 1'b1);
        drive_load(32'h150, 6'd4, 1'b0, 1'b1, 32'hCAFEF00D);
        drive_fetch(32'h140, 1'b1, 32'h00000513);
        release_ce();
        sw_data = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            check("sw_wr", 32'(mem_wr), 32'd1);
            check("sw_addr", mem_a, 32'h160 + 32'(k));
            check("sw_dout", 32'(mem_dout), 32'(sw_data[8*k +: 8]));
            tick();
        end
        check("sw_idle_wr", 32'(mem_wr), 32'd0);
        tick();
        check("arb_load_addr", mem_a, 32'h150);
        drain(40);
        check("sw_ram", ram_word(12'h160), 32'hDEADBEEF);

        // Misbranch during LW byte 2, then fetch 0x200
        drive_load(32'h170, 6'd4, 1'b0, 1'b0, 32'h0);
        release_ce();
        tick(); tick();
        check("mb_lw_addr", mem_a, 32'h172);
        in_rob_misbranch = 1'b1;
        tick();
        in_rob_misbranch = 1'b0;
        check("mb_wr", 32'(mem_wr), 32'd0);
        check("mb_idle_addr", mem_a, 32'd0);
        drive_fetch(32'h200, 1'b1, 32'h00100093);
        release_ce();
        check("mb_fetch_addr", mem_a, 32'h200);
        drain(20);
        for (int k = 0; k < 6; k++) begin
            check("mb_no_lsb", 32'(out_lsb_ce), 32'd0);
            tick();
        end

        // Misbranch during SW: store completes
        drive_store(32'h180, 6'd4, 32'h11223344, 1'b1);
        release_ce();
        tick();
        in_rob_misbranch = 1'b1;
        check("mbsw_wr1", 32'(mem_wr), 32'd1);
        tick();
        in_rob_misbranch = 1'b0;
        check("mbsw_wr2", 32'(mem_wr), 32'd1);
        tick();
        check("mbsw_wr3", 32'(mem_wr), 32'd1);
        check("mbsw_addr3", mem_a, 32'h183);
        tick();
        check("mbsw_rob_ce", 32'(out_rob_ce), 32'd1);
        drain(20);
        check("mbsw_ram", ram_word(12'h180), 32'h11223344);

        // SB to I/O region with io_buffer_full for 3 cycles
        io_buffer_full = 1'b1;
        drive_store(32'h30000, 6'd1, 32'h41, 1'b1);
        release_ce();
        for (int k = 0; k < 3; k++) begin
            check("io_hold_wr", 32'(mem_wr), 32'd0);
            check("io_hold_addr", mem_a, 32'h30000);
            tick();
        end
        io_buffer_full = 1'b0;
        #1;
        check("io_wr", 32'(mem_wr), 32'd1);
        check("io_dout", 32'(mem_dout), 32'h41);
        tick();
        check("io_rob_ce", 32'(out_rob_ce), 32'd1);
        drain(20);
        check("io_ram", 32'(ram[12'h000]), 32'h41);

        // Asynchronous reset mid-SW
        drive_store(32'h190, 6'd4, 32'h55667788, 1'b0);
        release_ce();
        tick();
        check("rstsw_wr_before", 32'(mem_wr), 32'd1);
        rst = 1'b0;
        #1;
        check("rstsw_wr", 32'(mem_wr), 32'd0);
        check("rstsw_addr", mem_a, 32'd0);
        check("rstsw_rob_ce", 32'(out_rob_ce), 32'd0);
        check("rstsw_lsb_ce", 32'(out_lsb_ce), 32'd0);
        check("rstsw_fetch_ce", 32'(out_fetcher_ce), 32'd0);
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("rstsw_no_rob", 32'(out_rob_ce), 32'd0);
            tick();
        end

        // rdy low for 2 cycles mid-LW: done delayed to C+8
        drive_load(32'h100, 6'd4, 1'b0, 1'b1, 32'h12345678);
        release_ce();
        check("stall_addr0", mem_a, 32'h100);
        tick();
        rdy = 1'b0;
        check("stall_addr1", mem_a, 32'h101);
        check("stall_wr", 32'(mem_wr), 32'd0);
        tick();
        check("stall_hold", mem_a, 32'h101);
        tick();
        rdy = 1'b1;
        check("stall_resume", mem_a, 32'h101);
        tick();
        check("stall_addr2", mem_a, 32'h102);
        tick();
        check("stall_addr3", mem_a, 32'h103);
        tick();
        check("stall_ce_early", 32'(out_lsb_ce), 32'd0);
        tick();
        check("stall_ce", 32'(out_lsb_ce), 32'd1);
        check("stall_data", out_lsb_data, 32'h12345678);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
